rotary_button: RTL and testbench

- Decodes a quadrature rotary encoder (rotA/rotB) into single-cycle left/right step pulses.
- Debounces the encoder's push switch (rotCenter) into a clean level output, down.
- Sits between the board's raw encoder pins and the UI/graphics control logic.
- One clock domain, 50 MHz nominal (20 ns period).

---
 rtl/rotary_button_if.sv | 29 ++
 rtl/rotary_button.sv | 89 ++++++++
 tb/tb_rotary_button.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_button_if.sv
// Encoder pin bundle between the raw board pins and the rotary/button decoder.
interface rotary_button_if;
  logic rotA;
  logic rotB;
  logic rotCenter;
  logic left;
  logic right;
  logic down;

  // Board side: drives the raw encoder pins, consumes decoded events.
  modport master (
    output rotA,
    output rotB,
    output rotCenter,
    input  left,
    input  right,
    input  down
  );

  // Decoder side: samples raw pins, produces step pulses and button level.
  modport slave (
    input  rotA,
    input  rotB,
    input  rotCenter,
    output left,
    output right,
    output down
  );
endinterface

// File: rtl/rotary_button.sv
// Quadrature rotary encoder decoder with a debounced push switch.
// left/right are single-cycle step pulses; down is a clean level.
module rotary_button #(
  parameter int unsigned DEBOUNCE_CYCLES = 250,
  parameter int unsigned CNT_W           = 9
) (
  input  logic            clk,
  input  logic            rst,
  rotary_button_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             rot_q1;
  logic             rot_q2;
  logic             rot_q1_d;
  logic             step_left;
  logic             step_right;
  logic             center_meta;
  logic             center_sync;
  logic             btn_down;
  logic [CNT_W-1:0] deb_cnt;
  logic             step_event_c;

  // Quadrature filter: 11/00 move rot_q1, 10/01 move rot_q2, so bounce on one
  // channel only toggles a flop that is already settled. Doubles as synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q1 <= 1'b0;
      rot_q2 <= 1'b0;
    end else begin
      case ({bus.rotA, bus.rotB})
        2'b11:   rot_q1 <= 1'b1;
        2'b00:   rot_q1 <= 1'b0;
        2'b10:   rot_q2 <= 1'b1;
        2'b01:   rot_q2 <= 1'b0;
        default: ;
      endcase
    end
  end

  // A detent completes on the rising edge of rot_q1; rot_q2 tells direction.
  assign step_event_c = rot_q1 & ~rot_q1_d;

  // Delayed rot_q1 plus registered one-cycle step pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q1_d   <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
    end else begin
      rot_q1_d   <= rot_q1;
      step_left  <= step_event_c & rot_q2;
      step_right <= step_event_c & ~rot_q2;
    end
  end

  // Two-flop synchronizer for the push switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      center_meta <= 1'b0;
      center_sync <= 1'b0;
    end else begin
      center_meta <= bus.rotCenter;
      center_sync <= center_meta;
    end
  end

  // Debounce: down follows the synchronized switch only after it has differed
  // for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt  <= '0;
      btn_down <= 1'b0;
    end else if (center_sync == btn_down) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      deb_cnt  <= '0;
      btn_down <= center_sync;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  assign bus.left  = step_left;
  assign bus.right = step_right;
  assign bus.down  = btn_down;

endmodule

// File: tb/tb_rotary_button.sv
// Directed bench for rotary_button: table of encoder moves with expected pulse
// counts, plus hand-written timing, bounce, debounce and reset sequences.
`timescale 1ns/1ps
module tb_rotary_button;

  localparam int unsigned DEB = 250;

  logic clk;
  logic rst;
  rotary_button_if bus ();

  rotary_button #(.DEBOUNCE_CYCLES(DEB), .CNT_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lcnt = 0;
  int rcnt = 0;
  int both_cnt = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.left)  lcnt++;
    if (bus.right) rcnt++;
    if (bus.left && bus.right) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        a;
    logic        b;
    int unsigned cycles;
    int          exp_l;
    int          exp_r;
  } vec_t;

  vec_t vecs[17];

  task automatic apply_ab(input logic a, input logic b);
    @(posedge clk);
    #2;
    bus.rotA = a;
    bus.rotB = b;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic early_glitch;

    // Idle, then left detent, return, right detent, return.
    vecs[0]  = '{1'b0, 1'b0, 50, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 75, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 75, 1, 0};
    vecs[3]  = '{1'b0, 1'b1, 75, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 75, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 75, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 75, 0, 1};
    vecs[7]  = '{1'b1, 1'b0, 75, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 75, 0, 0};
    // A starts, backs off, then a B-first move completes: right.
    vecs[9]  = '{1'b1, 1'b0, 20, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 20, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 20, 0, 0};
    vecs[12] = '{1'b1, 1'b1, 20, 0, 1};
    // A bouncing while parked at 11 must not step again.
    vecs[13] = '{1'b0, 1'b1, 10, 0, 0};
    vecs[14] = '{1'b1, 1'b1, 10, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 10, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 20, 0, 0};

    rst = 1'b1;
    bus.rotA = 1'b0;
    bus.rotB = 1'b0;
    bus.rotCenter = 1'b0;
    #5;
    rst = 1'b0;
    #1;
    check("reset_left", int'(bus.left), 0);
    check("reset_right", int'(bus.right), 0);
    check("reset_down", int'(bus.down), 0);

    // Table-driven encoder moves.
    for (int i = 0; i < 17; i++) begin
      apply_ab(vecs[i].a, vecs[i].b);
      lcnt = 0;
      rcnt = 0;
      wait_cycles(int'(vecs[i].cycles));
      check($sformatf("vec%0d_left", i), lcnt, vecs[i].exp_l);
      check($sformatf("vec%0d_right", i), rcnt, vecs[i].exp_r);
    end

    // Exact left-pulse timing: high 40 ns after B rises, one clock wide.
    apply_ab(1'b1, 1'b0);
    wait_cycles(75);
    apply_ab(1'b1, 1'b1);
    #20; check("left_t20", int'(bus.left), 0);
    #20; check("left_t40", int'(bus.left), 1);
    check("left_t40_right", int'(bus.right), 0);
    #20; check("left_t60", int'(bus.left), 0);
    apply_ab(1'b0, 1'b1);
    wait_cycles(20);
    apply_ab(1'b0, 1'b0);
    wait_cycles(20);

    // Exact right-pulse timing.
    apply_ab(1'b0, 1'b1);
    wait_cycles(75);
    apply_ab(1'b1, 1'b1);
    #40; check("right_t40", int'(bus.right), 1);
    check("right_t40_left", int'(bus.left), 0);
    #20; check("right_t60", int'(bus.right), 0);
    apply_ab(1'b1, 1'b0);
    wait_cycles(20);
    apply_ab(1'b0, 1'b0);
    wait_cycles(20);

    // Channel bounce: A=1, B toggles every 20 ns ending high -> one left.
    apply_ab(1'b1, 1'b0);
    wait_cycles(20);
    lcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.rotB = (i % 2 == 1) ? 1'b1 : 1'b0;
      #20;
    end
    wait_cycles(20);
    check("bounce_left", lcnt, 1);
    check("bounce_right", rcnt, 0);
    apply_ab(1'b0, 1'b1);
    wait_cycles(20);
    apply_ab(1'b0, 1'b0);
    wait_cycles(20);

    // Button press: down rises exactly DEB+2 edges after the input change.
    @(posedge clk); #2;
    bus.rotCenter = 1'b1;
    repeat (DEB + 1) @(posedge clk);
    #1; check("press_before", int'(bus.down), 0);
    @(posedge clk);
    #1; check("press_after", int'(bus.down), 1);
    early_glitch = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.down !== 1'b1) early_glitch = 1'b1;
    end
    check("press_held", int'(early_glitch), 0);

    // Release is symmetric.
    @(posedge clk); #2;
    bus.rotCenter = 1'b0;
    repeat (DEB + 1) @(posedge clk);
    #1; check("release_before", int'(bus.down), 1);
    @(posedge clk);
    #1; check("release_after", int'(bus.down), 0);
    wait_cycles(20);

    // Button bounce: 2 us high, 1 us low, then steady high.
    early_glitch = 1'b0;
    @(posedge clk); #2;
    bus.rotCenter = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.down !== 1'b0) early_glitch = 1'b1;
    end
    #1;
    bus.rotCenter = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.down !== 1'b0) early_glitch = 1'b1;
    end
    #1;
    bus.rotCenter = 1'b1;
    repeat (DEB + 1) begin
      @(posedge clk); #1;
      if (bus.down !== 1'b0) early_glitch = 1'b1;
    end
    check("bbounce_no_glitch", int'(early_glitch), 0);
    @(posedge clk);
    #1; check("bbounce_down", int'(bus.down), 1);

    // Reset mid-operation with encoder parked at 11.
    apply_ab(1'b0, 1'b1);
    wait_cycles(5);
    apply_ab(1'b1, 1'b1);
    wait_cycles(10);
    @(posedge clk); #5;
    rst = 1'b1;
    bus.rotCenter = 1'b0;
    #1;
    check("midrst_down", int'(bus.down), 0);
    check("midrst_left", int'(bus.left), 0);
    check("midrst_right", int'(bus.right), 0);
    wait_cycles(3);
    #2;
    lcnt = 0;
    rcnt = 0;
    rst = 1'b0;
    wait_cycles(10);
    check("postrst_right", rcnt, 1);
    check("postrst_left", lcnt, 0);
    check("postrst_down", int'(bus.down), 0);

    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
